// File: rtl/hex_text_pkg.sv
// Shared types and constants for the hex_text_stream block.
package hex_text_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SKIP = 2'd1,
        SEND = 2'd2,
        FIN  = 2'd3
    } state_t;

    localparam logic [7:0] ASCII_ZERO    = 8'h30;
    localparam logic [7:0] ASCII_UPPER_A = 8'h41;
    localparam logic [7:0] ASCII_LOWER_A = 8'h61;

endpackage

// File: rtl/hex_digit_ascii.sv
// Combinational nibble-to-ASCII mapping for a single hex digit.
module hex_digit_ascii
    import hex_text_pkg::*;
#(
    parameter int UPPER = 1
) (
    input  logic [3:0] nibble,
    output logic [7:0] ascii
);

    logic [7:0] letter_base;

    assign letter_base = (UPPER != 0) ? ASCII_UPPER_A : ASCII_LOWER_A;

    // Decimal digits map from '0', values 10..15 map from the selected letter base.
    always_comb begin
        if (nibble < 4'd10) begin
            ascii = ASCII_ZERO + {4'h0, nibble};
        end else begin
            ascii = letter_base + {4'h0, nibble} - 8'd10;
        end
    end

endmodule

// File: rtl/hex_text_stream.sv
// Converts a binary value into a stream of ASCII hex characters, MS digit first,
// over a valid/ready character interface with optional leading-zero suppression.
module hex_text_stream
    import hex_text_pkg::*;
#(
    parameter int WIDTH    = 18,
    parameter int UPPER    = 1,
    parameter int SUPPRESS = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] binary_in,
    output logic             busy,
    output logic [7:0]       char_out,
    output logic             char_valid,
    input  logic             char_ready,
    output logic             char_last,
    output logic             done
);

    localparam int NDIG = (WIDTH + 3) / 4;
    localparam int VW   = NDIG * 4;
    localparam int IW   = (NDIG > 1) ? $clog2(NDIG) : 1;

    state_t          state_reg, state_next;
    logic [VW-1:0]   value_reg, value_next;
    logic [IW-1:0]   index_reg, index_next;

    logic [VW-1:0]   start_ext;
    logic [IW-1:0]   idx_dec;
    logic [3:0]      cur_nibble;
    logic [3:0]      dec_nibble;
    logic [7:0]      cur_ascii;

    assign start_ext  = VW'(binary_in);
    assign idx_dec    = index_reg - IW'(1);
    assign cur_nibble = 4'(value_reg >> {index_reg, 2'b00});
    assign dec_nibble = 4'(value_reg >> {idx_dec, 2'b00});

    hex_digit_ascii #(
        .UPPER (UPPER)
    ) u_digit (
        .nibble (cur_nibble),
        .ascii  (cur_ascii)
    );

    // State, captured value and digit index; reset aborts any conversion in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
            value_reg <= '0;
            index_reg <= '0;
        end else begin
            state_reg <= state_next;
            value_reg <= value_next;
            index_reg <= index_next;
        end
    end

    // Next-state logic. SKIP looks one digit ahead so that it lasts exactly one
    // cycle per suppressed digit; a value whose MS digit is already non-zero
    // has nothing to skip and goes straight to SEND.
    always_comb begin
        state_next = state_reg;
        value_next = value_reg;
        index_next = index_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    value_next = start_ext;
                    index_next = IW'(NDIG - 1);
                    if (SUPPRESS != 0 && NDIG > 1 && start_ext[VW-1 -: 4] == 4'h0) begin
                        state_next = SKIP;
                    end else begin
                        state_next = SEND;
                    end
                end
            end
            SKIP: begin
                index_next = idx_dec;
                if (idx_dec == '0 || dec_nibble != 4'h0) begin
                    state_next = SEND;
                end
            end
            SEND: begin
                if (char_ready) begin
                    if (index_reg == '0) begin
                        state_next = FIN;
                    end else begin
                        index_next = idx_dec;
                    end
                end
            end
            FIN: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy       = (state_reg != IDLE);
    assign char_valid = (state_reg == SEND);
    assign char_last  = (state_reg == SEND) && (index_reg == '0);
    assign char_out   = (state_reg == SEND) ? cur_ascii : 8'h00;
    assign done       = (state_reg == FIN);

endmodule

// File: tb/tb_hex_text_stream.sv
// Scoreboard bench: four hex_text_stream instances with different parameter sets,
// stimulus pushes expected characters/timing, a single monitor pops and compares.
`timescale 1ns/1ps
module tb_hex_text_stream;

    localparam int NDUT = 4;

    function automatic int cfg_w(input int i);
        case (i)
            0:       return 18;
            1:       return 16;
            2:       return 16;
            default: return 1;
        endcase
    endfunction

    function automatic int cfg_up(input int i);
        return (i == 2) ? 0 : 1;
    endfunction

    function automatic int cfg_sup(input int i);
        return (i == 1) ? 1 : 0;
    endfunction

    logic       clk = 1'b0;
    logic       reset_n;
    logic       start      [NDUT];
    logic [63:0] bin       [NDUT];
    logic       char_ready [NDUT];
    logic       busy       [NDUT];
    logic [7:0] char_out   [NDUT];
    logic       char_valid [NDUT];
    logic       char_last  [NDUT];
    logic       done       [NDUT];

    int cyc     = 0;
    int n_tests = 0;
    int n_fail  = 0;
    bit end_req = 1'b0;

    int rmode [NDUT];
    int tbase [NDUT];

    logic [8:0] exp_q [NDUT][$];
    int         lat_q [NDUT][$];
    int         dur_q [NDUT][$];

    bit         prev_valid   [NDUT];
    bit         stalled      [NDUT];
    bit         pending_done [NDUT];
    logic [7:0] held_ch      [NDUT];
    logic       held_last    [NDUT];
    int         first_cyc    [NDUT];

    for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
        localparam int W = cfg_w(gi);
        hex_text_stream #(
            .WIDTH    (W),
            .UPPER    (cfg_up(gi)),
            .SUPPRESS (cfg_sup(gi))
        ) u_dut (
            .clk        (clk),
            .reset_n    (reset_n),
            .start      (start[gi]),
            .binary_in  (bin[gi][W-1:0]),
            .busy       (busy[gi]),
            .char_out   (char_out[gi]),
            .char_valid (char_valid[gi]),
            .char_ready (char_ready[gi]),
            .char_last  (char_last[gi]),
            .done       (done[gi])
        );
    end

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input bit ok, input string name, input int i,
                       input longint act, input longint req);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %0h, required %0h (cycle %0d)", name, i, act, req, cyc);
        end
    endtask

    // Consumer ready: 0 = always ready, 1 = toggling (low on the first valid cycle), 2 = random.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < NDUT; i++) begin
                case (rmode[i])
                    0:       char_ready[i] = 1'b1;
                    1:       char_ready[i] = ((cyc - tbase[i]) & 1) != 0;
                    default: char_ready[i] = ($urandom_range(0, 3) != 0);
                endcase
            end
        end
    end

    // Monitor: compares every DUT against the scoreboard on the falling edge.
    initial begin
        logic [8:0] e;
        int         d;
        for (int i = 0; i < NDUT; i++) begin
            prev_valid[i]   = 1'b0;
            stalled[i]      = 1'b0;
            pending_done[i] = 1'b0;
            first_cyc[i]    = 0;
        end
        forever begin
            @(negedge clk);
            if (cyc > 40000) begin
                chk(1'b0, "watchdog_expired", 0, cyc, 40000);
                $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
                $finish;
            end
            for (int i = 0; i < NDUT; i++) begin
                if (!reset_n) begin
                    chk(busy[i] == 1'b0 && char_valid[i] == 1'b0 && char_last[i] == 1'b0 &&
                        done[i] == 1'b0 && char_out[i] == 8'h00, "reset_outputs", i,
                        {busy[i], char_valid[i], char_last[i], done[i], char_out[i]}, 0);
                    exp_q[i].delete();
                    lat_q[i].delete();
                    dur_q[i].delete();
                    prev_valid[i]   = 1'b0;
                    stalled[i]      = 1'b0;
                    pending_done[i] = 1'b0;
                end else begin
                    if (pending_done[i]) begin
                        chk(done[i] == 1'b1 && busy[i] == 1'b1 && char_valid[i] == 1'b0, "done_pulse", i,
                            {done[i], busy[i], char_valid[i]}, 3'b110);
                        pending_done[i] = 1'b0;
                    end else begin
                        chk(done[i] == 1'b0, "spurious_done", i, done[i], 0);
                    end
                    if (char_valid[i] && !prev_valid[i]) begin
                        first_cyc[i] = cyc;
                        if (lat_q[i].size() > 0) begin
                            d = lat_q[i].pop_front();
                            chk(cyc == d, "first_valid_cycle", i, cyc, d);
                        end else begin
                            chk(1'b0, "unexpected_valid", i, cyc, 0);
                        end
                    end
                    if (stalled[i]) begin
                        chk(char_valid[i] && char_out[i] == held_ch[i] && char_last[i] == held_last[i],
                            "stall_stable", i, {char_valid[i], char_last[i], char_out[i]},
                            {1'b1, held_last[i], held_ch[i]});
                    end
                    if (char_valid[i]) begin
                        chk(busy[i] == 1'b1, "busy_in_send", i, busy[i], 1);
                    end
                    if (char_valid[i] && char_ready[i]) begin
                        stalled[i] = 1'b0;
                        $display("[TB] dut%0d char '%c' (%02h) last=%0b cycle %0d",
                                 i, char_out[i], char_out[i], char_last[i], cyc);
                        if (exp_q[i].size() > 0) begin
                            e = exp_q[i].pop_front();
                            chk({char_last[i], char_out[i]} == e, "char", i,
                                {char_last[i], char_out[i]}, e);
                        end else begin
                            chk(1'b0, "unexpected_char", i, char_out[i], 0);
                        end
                        if (char_last[i]) begin
                            pending_done[i] = 1'b1;
                            if (dur_q[i].size() > 0) begin
                                d = dur_q[i].pop_front();
                                if (d >= 0) begin
                                    chk(cyc - first_cyc[i] == d, "stream_cycles", i, cyc - first_cyc[i], d);
                                end
                            end
                        end
                    end else if (char_valid[i]) begin
                        stalled[i]   = 1'b1;
                        held_ch[i]   = char_out[i];
                        held_last[i] = char_last[i];
                    end else begin
                        stalled[i] = 1'b0;
                    end
                    prev_valid[i] = char_valid[i];
                end
            end
            if (end_req) begin
                for (int i = 0; i < NDUT; i++) begin
                    chk(exp_q[i].size() == 0 && lat_q[i].size() == 0, "leftover_expected", i,
                        exp_q[i].size() + lat_q[i].size(), 0);
                end
                $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
                $finish;
            end
        end
    end

    // Reference model: the value printed as hex text, trimmed to NDIG digits or
    // with leading zeros removed, then queued with the expected timing.
    task automatic issue(input int i, input logic [63:0] v, input int mode);
        int w, nd, k, n;
        logic [63:0] m;
        string full, text;
        w  = cfg_w(i);
        nd = (w + 3) / 4;
        m  = (w >= 64) ? v : (v & ((64'd1 << w) - 64'd1));
        full = $sformatf("%h", m);
        if (cfg_sup(i) != 0) text = $sformatf("%0h", m);
        else                 text = full.substr(16 - nd, 15);
        if (cfg_up(i) != 0) text = text.toupper();
        n = text.len();
        k = nd - n;
        for (int j = 0; j < n; j++) begin
            exp_q[i].push_back({(j == n - 1), text[j]});
        end
        @(posedge clk);
        #1;
        rmode[i] = mode;
        tbase[i] = cyc + 1 + k;
        lat_q[i].push_back(cyc + 1 + k);
        dur_q[i].push_back(mode == 0 ? n - 1 : (mode == 1 ? 2 * n - 1 : -1));
        bin[i]   = v;
        start[i] = 1'b1;
    endtask

    // Drop start, then scramble binary_in (and optionally pulse start) until idle again.
    task automatic finish_conv(input int i, input bit noise);
        @(posedge clk);
        #1;
        start[i] = 1'b0;
        for (int t = 0; t < 300; t++) begin
            if (!busy[i]) break;
            bin[i] = {$urandom, $urandom};
            if (noise) start[i] = done[i] ? 1'b1 : 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
        end
        start[i] = 1'b0;
    endtask

    task automatic convert(input int i, input logic [63:0] v, input int mode, input bit noise);
        issue(i, v, mode);
        finish_conv(i, noise);
    endtask

    // Pull reset during the third character of an 18'h2ABCD conversion.
    task automatic reset_mid();
        issue(0, 64'h2ABCD, 0);
        @(posedge clk);
        #1;
        start[0] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (3) @(posedge clk);
    endtask

    // Stimulus: directed cases first, then randomized conversions.
    initial begin
        reset_n = 1'b0;
        for (int i = 0; i < NDUT; i++) begin
            start[i] = 1'b0;
            bin[i]   = '0;
            rmode[i] = 0;
            tbase[i] = 0;
        end
        repeat (4) @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (2) @(posedge clk);

        convert(0, 64'h2ABCD, 0, 1'b0);
        convert(1, 64'h00F0,  0, 1'b0);
        convert(1, 64'h0,     0, 1'b0);
        convert(2, 64'hBEEF,  1, 1'b0);
        convert(3, 64'h1,     0, 1'b0);
        convert(3, 64'h0,     0, 1'b0);
        convert(0, 64'h3F00A, 2, 1'b1);
        reset_mid();
        convert(0, 64'h1234F, 0, 1'b0);

        for (int r = 0; r < 60; r++) begin
            convert($urandom_range(0, 3), {$urandom, $urandom} >> $urandom_range(0, 63),
                    $urandom_range(0, 2), 1'($urandom_range(0, 1)));
        end

        repeat (10) @(posedge clk);
        #1;
        end_req = 1'b1;
    end

endmodule
